hpdcache_refill_writer: RTL and testbench



---
 rtl/hpdcache_pkg.sv | 29 ++
 rtl/hpdcache_refill_writer.sv | 144 ++++++++++++++
 tb/tb_hpdcache_refill_writer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_pkg.sv
// -----------------------------------------------------------------------------
// hpdcache_pkg
// Shared types and size helpers for the HPDcache refill path.
//   - refill word, set index and way index types at the default geometry
//   - hpdc_words()       : number of refill words per cache line
//   - hpdc_word_idx_w()  : width of a word index within a line (at least 1)
// -----------------------------------------------------------------------------
package hpdcache_pkg;

    localparam int unsigned HPDC_RD_WIDTH   = 128;
    localparam int unsigned HPDC_LINE_WIDTH = 512;
    localparam int unsigned HPDC_SET_WIDTH  = 7;
    localparam int unsigned HPDC_WAY_WIDTH  = 2;

    typedef logic [HPDC_RD_WIDTH-1:0]  hpdc_refill_word_t;
    typedef logic [HPDC_SET_WIDTH-1:0] hpdc_set_t;
    typedef logic [HPDC_WAY_WIDTH-1:0] hpdc_way_t;

    function automatic int unsigned hpdc_words(input int unsigned line_w,
                                               input int unsigned rd_w);
        return line_w / rd_w;
    endfunction

    // A single-word line still needs a 1-bit index port.
    function automatic int unsigned hpdc_word_idx_w(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_refill_writer.sv
// -----------------------------------------------------------------------------
// hpdcache_refill_writer
// Pops assembled refill words from the upsize FIFO and writes them, in word
// order, into the data RAM for one cache line per start request. A single
// output register decouples the FIFO pop from the RAM grant while sustaining
// one word per cycle. done_o pulses once the last word of the line is granted.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i/_set_i/_way_i         new line request and its target set/way
//   start_ready_o                 high in IDLE only
//   rok_i, r_o, rdata_i           upstream FIFO valid / pop strobe / head word
//   ram_req_o, ram_gnt_i          data RAM write request / grant
//   ram_set_o/_way_o/_word_o      write address (registered)
//   ram_wdata_o                   write data (registered)
//   done_o                        one-cycle line completion pulse
//   busy_o                        a line is in progress
// -----------------------------------------------------------------------------
module hpdcache_refill_writer
    import hpdcache_pkg::*;
#(
    parameter int unsigned RD_WIDTH   = 128,
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned SET_WIDTH  = 7,
    parameter int unsigned WAY_WIDTH  = 2,
    localparam int unsigned WORDS      = hpdc_words(LINE_WIDTH, RD_WIDTH),
    localparam int unsigned WORD_IDX_W = hpdc_word_idx_w(WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  start_i,
    input  logic [SET_WIDTH-1:0]  start_set_i,
    input  logic [WAY_WIDTH-1:0]  start_way_i,
    output logic                  start_ready_o,

    input  logic                  rok_i,
    output logic                  r_o,
    input  logic [RD_WIDTH-1:0]   rdata_i,

    output logic                  ram_req_o,
    input  logic                  ram_gnt_i,
    output logic [SET_WIDTH-1:0]  ram_set_o,
    output logic [WAY_WIDTH-1:0]  ram_way_o,
    output logic [WORD_IDX_W-1:0] ram_word_o,
    output logic [RD_WIDTH-1:0]   ram_wdata_o,

    output logic                  done_o,
    output logic                  busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WORD_IDX_W:0]   ISSUE_MAX = (WORD_IDX_W+1)'(WORDS);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS - 1);

    logic [1:0]            state_q, state_d;
    logic                  v_q, v_d;
    logic [WORD_IDX_W:0]   issue_q, issue_d;
    logic [SET_WIDTH-1:0]  set_q;
    logic [WAY_WIDTH-1:0]  way_q;
    logic [WORD_IDX_W-1:0] word_q;
    logic [RD_WIDTH-1:0]   wdata_q;

    logic start_acc;
    logic pop;
    logic gnt;
    logic last_gnt;

    assign start_acc = (state_q == ST_IDLE) && start_i;

    // The output register may reload in the same cycle its content is granted.
    assign pop = !rst_i && (state_q == ST_FILL) && rok_i &&
                 (issue_q < ISSUE_MAX) && (!v_q || ram_gnt_i);

    // A grant only counts while a request is actually presented.
    assign gnt      = v_q && ram_gnt_i;
    assign last_gnt = gnt && (word_q == LAST_WORD);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i)  state_d = ST_FILL;
            ST_FILL: if (last_gnt) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        v_d = v_q;
        if (pop) begin
            v_d = 1'b1;
        end else if (gnt) begin
            v_d = 1'b0;
        end
    end

    always_comb begin
        issue_d = issue_q;
        if (start_acc) begin
            issue_d = '0;
        end else if (pop) begin
            issue_d = issue_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            v_q     <= 1'b0;
            issue_q <= '0;
            set_q   <= '0;
            way_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            issue_q <= issue_d;
            if (start_acc) begin
                set_q <= start_set_i;
                way_q <= start_way_i;
            end
            if (pop) begin
                wdata_q <= rdata_i;
                word_q  <= issue_q[WORD_IDX_W-1:0];
            end
        end
    end

    assign r_o           = pop;
    assign ram_req_o     = v_q;
    assign ram_set_o     = set_q;
    assign ram_way_o     = way_q;
    assign ram_word_o    = word_q;
    assign ram_wdata_o   = wdata_q;
    assign start_ready_o = (state_q == ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hpdcache_refill_writer.sv
// -----------------------------------------------------------------------------
// tb_hpdcache_refill_writer
// Scoreboard bench: each line started pushes its expected RAM writes
// (set, way, word index, data in order) into a queue; an independent monitor
// pops and compares on every granted write and tracks the done pulse.
// -----------------------------------------------------------------------------
module tb_hpdcache_refill_writer;

    localparam int RDW   = 128;
    localparam int SETW  = 7;
    localparam int WAYW  = 2;
    localparam int WORDS = 4;
    localparam int WIW   = 2;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            start_i = 1'b0;
    logic [SETW-1:0] start_set_i = '0;
    logic [WAYW-1:0] start_way_i = '0;
    logic            start_ready_o;
    logic            rok_i = 1'b0;
    logic            r_o;
    logic [RDW-1:0]  rdata_i = '0;
    logic            ram_req_o;
    logic            ram_gnt_i = 1'b0;
    logic [SETW-1:0] ram_set_o;
    logic [WAYW-1:0] ram_way_o;
    logic [WIW-1:0]  ram_word_o;
    logic [RDW-1:0]  ram_wdata_o;
    logic            done_o;
    logic            busy_o;

    always #5 clk = ~clk;

    hpdcache_refill_writer #(
        .RD_WIDTH   (RDW),
        .LINE_WIDTH (RDW * WORDS),
        .SET_WIDTH  (SETW),
        .WAY_WIDTH  (WAYW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .start_set_i   (start_set_i),
        .start_way_i   (start_way_i),
        .start_ready_o (start_ready_o),
        .rok_i         (rok_i),
        .r_o           (r_o),
        .rdata_i       (rdata_i),
        .ram_req_o     (ram_req_o),
        .ram_gnt_i     (ram_gnt_i),
        .ram_set_o     (ram_set_o),
        .ram_way_o     (ram_way_o),
        .ram_word_o    (ram_word_o),
        .ram_wdata_o   (ram_wdata_o),
        .done_o        (done_o),
        .busy_o        (busy_o)
    );

    typedef struct packed {
        logic [SETW-1:0] set;
        logic [WAYW-1:0] way;
        logic [WIW-1:0]  word;
        logic [RDW-1:0]  data;
    } wr_t;

    wr_t            exp_q[$];
    logic [RDW-1:0] fifo_q[$];

    int checks   = 0;
    int failures = 0;

    // Per-line observations gathered by the stimulus side.
    bit accepted;
    bit saw_done;
    int line_pops;
    int line_reqs;
    int line_grants;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [RDW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: all inputs change on the falling edge, outputs are
    // sampled 1 time unit later, and the FIFO model commits the pop that the
    // next rising edge performs.
    task automatic step(input bit wr, input bit wg, input bit rst, input bit st,
                        input logic [SETW-1:0] sset, input logic [WAYW-1:0] sway);
        @(negedge clk);
        rst_i       = rst;
        start_i     = st;
        start_set_i = sset;
        start_way_i = sway;
        rok_i       = wr && (fifo_q.size() != 0);
        rdata_i     = (fifo_q.size() != 0) ? fifo_q[0] : rand_word();
        ram_gnt_i   = wg;
        #1;
        accepted = start_i && start_ready_o && !rst_i;
        saw_done = done_o;
        if (ram_req_o) line_reqs++;
        if (ram_req_o && ram_gnt_i && !rst_i) line_grants++;
        if (r_o && (fifo_q.size() != 0)) begin
            void'(fifo_q.pop_front());
            line_pops++;
        end
    endtask

    // Queue one line: data words into the FIFO model (plus one trailing word
    // that belongs to nobody and must never be popped) and the expected writes.
    task automatic load_line(input logic [SETW-1:0] s, input logic [WAYW-1:0] w);
        logic [RDW-1:0] d;
        for (int i = 0; i < WORDS; i++) begin
            d = rand_word();
            fifo_q.push_back(d);
            exp_q.push_back('{set: s, way: w, word: WIW'(i), data: d});
        end
        fifo_q.push_back(rand_word());
        line_pops   = 0;
        line_reqs   = 0;
        line_grants = 0;
    endtask

    task automatic run_line(input logic [SETW-1:0] s, input logic [WAYW-1:0] w,
                            input int unsigned rok_pct, input int unsigned gnt_pct,
                            input logic [63:0] rok_mask, input logic [63:0] gnt_mask,
                            input bit busy_start, input bit check_lat);
        bit done_seen;
        int lat;
        bit wr;
        bit wg;
        done_seen = 0;
        lat       = 0;
        load_line(s, w);
        step(1'b1, 1'b1, 1'b0, 1'b1, s, w);
        chk("start_accepted", accepted, 1);
        line_pops = 0;
        line_reqs = 0;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            wr = ((i < 64) ? rok_mask[i] : 1'b1) && ($urandom_range(99) < rok_pct);
            wg = ((i < 64) ? gnt_mask[i] : 1'b1) && ($urandom_range(99) < gnt_pct);
            if (busy_start && i == 2) begin
                step(wr, wg, 1'b0, 1'b1, 7'd9, 2'd1);
                chk("busy_start_refused", accepted, 0);
            end else begin
                step(wr, wg, 1'b0, 1'b0, SETW'($urandom), WAYW'($urandom));
            end
            if (saw_done) begin
                done_seen = 1;
                lat = i + 1;
            end
        end
        if (!done_seen) begin
            fail_now("line_timeout");
        end else begin
            chk("pops_per_line", line_pops, WORDS);
            if (check_lat) begin
                chk("done_latency", lat, WORDS + 2);
                chk("req_cycles", line_reqs, WORDS);
            end
        end
        fifo_q.delete();
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    bit   pend_done = 0;
    bit   prev_ok   = 0;
    logic prev_req;
    logic prev_gnt;
    wr_t  prev_out;

    always @(negedge clk) begin
        wr_t cur;
        wr_t e;
        #2;
        if (rst_i) begin
            chk("r_o_in_reset", r_o, 0);
            pend_done = 0;
            prev_ok   = 0;
        end else begin
            cur = '{set: ram_set_o, way: ram_way_o, word: ram_word_o, data: ram_wdata_o};
            if (pend_done || done_o) chk("done_pulse", done_o, pend_done);
            pend_done = 0;
            if (r_o) chk("pop_needs_rok", rok_i, 1);
            if (ram_req_o && !ram_gnt_i) chk("no_pop_in_stall", r_o, 0);
            if (prev_ok && prev_req && !prev_gnt) begin
                chk("stall_req_held", ram_req_o, 1);
                chk("stall_outputs_held", cur, prev_out);
            end
            if (ram_req_o && ram_gnt_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    chk("ram_write", cur, e);
                    if (e.word == WIW'(WORDS - 1)) pend_done = 1;
                end
            end
            prev_ok  = 1;
            prev_req = ram_req_o;
            prev_gnt = ram_gnt_i;
            prev_out = cur;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;

        // Reset with the FIFO offering data and the RAM granting.
        fifo_q.push_back(rand_word());
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        fifo_q.delete();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_ram_req", ram_req_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_start_ready", start_ready_o, 1);

        // Full-throughput line.
        run_line(7'd5, 2'd2, 100, 100, '1, '1, 1'b0, 1'b1);
        // Grant withheld for three cycles while word 1 is presented.
        run_line(7'd5, 2'd2, 100, 100, '1, 64'hFFFF_FFFF_FFFF_FFE3, 1'b0, 1'b0);
        // FIFO bubbles on alternate cycles.
        run_line(7'd5, 2'd2, 100, 100, 64'h5555_5555_5555_5555, '1, 1'b0, 1'b0);
        // Start attempted mid-line, then a real start at set 9.
        run_line(7'd5, 2'd2, 100, 100, '1, '1, 1'b1, 1'b0);
        run_line(7'd9, 2'd1, 100, 100, '1, '1, 1'b0, 1'b0);

        // Reset after two grants abandons the line.
        load_line(7'd3, 2'd3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'd3, 2'd3);
        guard = 0;
        while (line_grants < 2 && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
            guard++;
        end
        if (line_grants < 2) fail_now("midline_grant_timeout");
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        exp_q.delete();
        fifo_q.delete();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        chk("midrst_req", ram_req_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ready", start_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            chk("midrst_no_done", done_o, 0);
        end
        run_line(7'd4, 2'd0, 100, 100, '1, '1, 1'b0, 1'b1);

        // Randomised lines with random FIFO and RAM backpressure.
        for (int n = 0; n < 20; n++) begin
            run_line(SETW'($urandom), WAYW'($urandom),
                     $urandom_range(30, 100), $urandom_range(30, 100),
                     '1, '1, 1'b0, 1'b0);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
